// File: rtl/uart_recv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_recv_pkg
//  Description : Shared UART definitions. The receiver (uart_recv) and the
//                transmitter both import this package.
//                - default frame geometry (data bits, oversampling rate)
//                - mid-bit sample ticks used by the 2-of-3 vote
//                - FSM state encoding
//                - 2-of-3 majority helper
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_recv_pkg;

    // Frame geometry defaults
    localparam int UART_SIZE = 8;   // data bits per frame
    localparam int OS_RATE   = 16;  // Baud16x ticks per bit period
    localparam int CNT_W     = 4;   // tick counter width (wraps 15 -> 0)
    localparam int IDX_W     = 3;   // data bit index width

    // Tick counter values at which the line is sampled. These are the
    // centre of the bit period; the decision is taken on the last one.
    localparam int SAMPLE_1 = 7;
    localparam int SAMPLE_2 = 8;
    localparam int SAMPLE_3 = 9;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 2-of-3 majority
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_recv_pkg
`default_nettype wire

// File: rtl/uart_recv_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_recv_if
//  Description : Consumer-side bus of the UART receiver.
//                Ports carried:
//                  ack        consumer read strobe (consumer -> receiver)
//                  data_rec   last received word
//                  rdy        new word available (level)
//                  Int_R      one-cycle pulse per completed frame
//                  frame_err  stop bit of last frame sampled low
//                  overrun    frame completed while rdy was still high
//                  busy       receiver not idle
//                Modports: master = receiver, slave = consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_recv_if #(
    parameter int uart_size = 8
);
    logic                 ack;
    logic [uart_size-1:0] data_rec;
    logic                 rdy;
    logic                 Int_R;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  ack,
        output data_rec,
        output rdy,
        output Int_R,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output ack,
        input  data_rec,
        input  rdy,
        input  Int_R,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface : uart_recv_if
`default_nettype wire

// File: rtl/uart_recv_sample_vote.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sample_vote
//  Description : 2-of-3 majority sampler. Captures the synchronised line at
//                the first two sample ticks and combines them with the live
//                value so the vote is valid on the third sample tick.
//                Ports:
//                  Baud16x  oversampling clock
//                  rst      asynchronous active-low reset
//                  cnt      receiver tick counter
//                  din      synchronised serial line
//                  vote     majority of the three samples
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sample_vote
    import uart_recv_pkg::*;
(
    input  wire logic             Baud16x,
    input  wire logic             rst,
    input  wire logic [CNT_W-1:0] cnt,
    input  wire logic             din,
    output logic                  vote
);

    logic r_s1;
    logic r_s2;

    // Samples reset to the idle line level.
    always_ff @(posedge Baud16x or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            if (cnt == CNT_W'(SAMPLE_1)) begin
                r_s1 <= din;
            end
            if (cnt == CNT_W'(SAMPLE_2)) begin
                r_s2 <= din;
            end
        end
    end

    // Third sample is the live value, so vote is meaningful at SAMPLE_3.
    assign vote = majority3(r_s1, r_s2, din);

endmodule : uart_sample_vote
`default_nettype wire

// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
//  Module      : uart_recv
//  Description : UART receiver, 16x oversampled, LSB first, one stop bit.
//                Start detection on a synchronised falling edge, mid-bit
//                2-of-3 majority sampling, frame/overrun error reporting.
//                Ports:
//                  Baud16x  oversampling clock (16x baud, rising edge)
//                  rst      asynchronous active-low reset
//                  rxd      serial line, idle high, asynchronous
//                  rx       consumer bus (uart_recv_if.master)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_recv
    import uart_recv_pkg::*;
#(
    parameter int uart_size = UART_SIZE,
    parameter int os_rate   = OS_RATE
) (
    input  wire logic    Baud16x,
    input  wire logic    rst,
    input  wire logic    rxd,
    uart_recv_if.master  rx
);

    // ------------------------------------------------------------------
    // Input synchroniser. r_rxd_prev holds the previous synchronised value
    // for falling-edge detection; all three reset to the idle level so a
    // line held low through reset release is not mistaken for a start.
    // ------------------------------------------------------------------
    logic r_rxd_meta;
    logic r_rxd_s;
    logic r_rxd_prev;

    always_ff @(posedge Baud16x or negedge rst) begin
        if (!rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rxd_prev <= r_rxd_s;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [uart_size-1:0] r_shift;
    logic [uart_size-1:0] r_data_rec;
    logic                 r_rdy;
    logic                 r_int_r;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    logic w_vote;
    logic w_wrap;
    logic w_decide;
    logic w_fall;
    logic w_last_bit;

    uart_sample_vote u_vote (
        .Baud16x (Baud16x),
        .rst     (rst),
        .cnt     (r_cnt),
        .din     (r_rxd_s),
        .vote    (w_vote)
    );

    assign w_wrap     = (r_cnt == CNT_W'(os_rate - 1));
    assign w_decide   = (r_cnt == CNT_W'(SAMPLE_3));
    assign w_fall     = r_rxd_prev & ~r_rxd_s;
    assign w_last_bit = (r_bit_idx == IDX_W'(uart_size - 1));

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Baud16x or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data_rec  <= '0;
            r_rdy       <= 1'b0;
            r_int_r     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_int_r <= 1'b0;

            // Consumer read. A completion on this same edge overrides
            // the clear further down, so a new word is never lost.
            if (rx.ack) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end

            // Free-running bit-period counter outside IDLE.
            if (r_state != ST_IDLE) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_decide && w_vote) begin
                        // Start bit not confirmed at mid-bit: a glitch.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                    end
                end

                ST_DATA: begin
                    if (w_decide) begin
                        // LSB arrives first and ends up at bit 0.
                        r_shift <= {w_vote, r_shift[uart_size-1:1]};
                    end
                    if (w_wrap) begin
                        if (w_last_bit) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    // Complete at mid stop bit so the FSM is back in IDLE
                    // well before the next start edge can arrive.
                    if (w_decide) begin
                        r_data_rec  <= r_shift;
                        r_rdy       <= 1'b1;
                        r_int_r     <= 1'b1;
                        r_frame_err <= ~w_vote;
                        r_overrun   <= rx.ack ? 1'b0 : (r_overrun | r_rdy);
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx.data_rec  = r_data_rec;
    assign rx.rdy       = r_rdy;
    assign rx.Int_R     = r_int_r;
    assign rx.frame_err = r_frame_err;
    assign rx.overrun   = r_overrun;
    assign rx.busy      = r_busy;

endmodule : uart_recv
`default_nettype wire

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter: uart_size, 8, number of data bits per frame.
REQ-002 SHALL have parameter: os_rate, 16, Baud16x ticks per bit period.
REQ-003 SHALL have port: Baud16x  input  1  oversampling clock, 16x baud rate, rising-edge active.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: rxd  input  1  serial line, idle high, asynchronous to Baud16x.
REQ-006 SHALL have port: ack  input  1  consumer read strobe; clears rdy on the edge it is sampled high.
REQ-007 SHALL have port: data_rec  output  uart_size  last received byte, LSB received first.
REQ-008 SHALL have port: rdy  output  1  level; new byte available in data_rec.
REQ-009 SHALL have port: Int_R  output  1  one-cycle pulse per completed frame, good or bad.
REQ-010 SHALL have port: frame_err  output  1  stop bit of last frame sampled low.
REQ-011 SHALL have port: overrun  output  1  a frame completed while rdy was still high.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer (rxd_s); no other logic reads rxd directly.
REQ-014 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE with a 4-bit tick counter cnt and a 3-bit bit index.
REQ-015 IDLE: on an edge where rxd_s=0 and previous rxd_s=1, SHALL go to START with cnt=0; define this edge T0.
REQ-016 cnt SHALL increment every edge outside IDLE and wrap 15->0; each wrap ends one bit period.
REQ-017 Each bit SHALL be sampled at cnt=7,8,9 and decided by 2-of-3 majority on the cnt=9 edge.
REQ-018 START: a majority of 1 SHALL be treated as a glitch and return the FSM to IDLE with no flags changed; a majority of 0 SHALL proceed to DATA at the next wrap.
REQ-019 DATA: SHALL shift decided bits into a shift register LSB-first; after bit uart_size-1 it SHALL go to STOP at wrap.
REQ-020 STOP: on the cnt=9 edge (T0+154 for uart_size=8) SHALL load data_rec, set rdy=1, pulse Int_R, set frame_err to the inverse of the stop decision, and return to IDLE on that same edge.
REQ-021 A frame with frame_err=1 SHALL still load data_rec and set rdy.
REQ-022 On frame completion with rdy=1 and ack=0, SHALL set overrun=1 and overwrite data_rec.
REQ-023 If ack=1 on the completion edge, completion SHALL win: rdy stays 1 and overrun is not set.
REQ-024 ack=1 with no completion SHALL clear rdy and overrun; frame_err SHALL be updated only at frame completion.
REQ-025 A line held low (break) SHALL produce exactly one frame with data_rec=0 and frame_err=1; no new start is detected until rxd_s returns high.
REQ-026 The FSM SHALL be receptive to a new start bit on the edge after returning to IDLE, so back-to-back frames from the transmitter are received without loss.

Reset
REQ-027 rst low SHALL asynchronously force: FSM=IDLE, cnt=0, synchronizer flops=1, data_rec=0, rdy=0, Int_R=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a fresh high-to-low transition.

Structure
REQ-029 uart_size, os_rate, the sample ticks (7,8,9) and the FSM state encodings SHALL live in a shared uart package also used by the transmitter.
REQ-030 The 2-of-3 majority sampler SHALL be a separate sub-module uart_sample_vote; everything else is a single module.

Verification
REQ-031 Loopback from the team transmitter, data_tra=8'hA5 -> rdy rises at T0+154 +/-1 tick, data_rec=8'hA5, frame_err=0, one Int_R pulse.
REQ-032 Low glitch of 4 ticks on idle rxd -> FSM returns to IDLE, rdy/Int_R/flags unchanged.
REQ-033 Two frames 8'h3C then 8'hC3 with no ack -> data_rec=8'hC3, rdy=1, overrun=1; ack -> rdy=0, overrun=0.
REQ-034 Frame 8'h55 with stop bit driven low -> data_rec=8'h55, frame_err=1; next good frame 8'h0F -> frame_err=0.
REQ-035 Single-tick inverted spike at cnt=8 of every data bit of 8'h96 -> data_rec=8'h96 (majority vote rejects it).
REQ-036 rst pulsed low during bit 4 of 8'hFF, then full frame 8'h81 -> busy=0 and rdy=0 during reset, then data_rec=8'h81, rdy=1.
